spy_chain_sensor: RTL

- Parametrised delay-line timing sensor built from a chain of the team's inverting path cells (singlepath_3_spy_p35, side inputs tied 0,0,1,0).
- Launches a rising edge into the chain, captures evenly spaced taps exactly one clock later, and converts them to a propagation depth.
- Averages 2^AVG_LOG2 samples and reports mean, min, max and a saturation flag through a valid/ready handshake.
- Sits beside victim logic as the measurement front end of the spy/delay-observation flow.

---
 rtl/spy_pkg.sv | 30 +++
 rtl/singlepath_3_spy_p35.sv | 14 +
 rtl/spy_tap_chain.sv | 41 ++++
 rtl/spy_chain_sensor.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/spy_pkg.sv
// Shared types and constants for the spy delay-line timing sensor.
package spy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      SAMPLE,
      SYNC,
      EVAL,
      SETTLE,
      DONE
   } SpyState;

   localparam int DEFAULT_CHAIN_LEN  = 50;
   localparam int DEFAULT_TAP_STRIDE = 5;

   // Side-input ties that reduce the path cell to a plain inverter
   localparam logic CELL_SIDE_A = 1'b0;
   localparam logic CELL_SIDE_B = 1'b0;
   localparam logic CELL_SIDE_C = 1'b1;
   localparam logic CELL_SIDE_D = 1'b0;

   function automatic int spyClog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/singlepath_3_spy_p35.sv
// Functional model of the lab's inverting path cell; side inputs select the
// cell behaviour, and the sensor ties them so the cell acts as an inverter.
module singlepath_3_spy_p35 (
   input  logic pathIn,
   input  logic sideA,
   input  logic sideB,
   input  logic sideC,
   input  logic sideD,
   output logic pathOut
);

   assign pathOut = (sideC & ~(pathIn | sideB)) | (sideD & sideA);

endmodule

// File: rtl/spy_tap_chain.sv
// Series chain of inverting path cells with evenly spaced, polarity-corrected taps.
module spy_tap_chain
   import spy_pkg::*;
#(
   parameter  int CHAIN_LEN  = DEFAULT_CHAIN_LEN,
   parameter  int TAP_STRIDE = DEFAULT_TAP_STRIDE,
   localparam int NUM_TAPS   = CHAIN_LEN / TAP_STRIDE
) (
   input  logic                launch,
   output logic [NUM_TAPS-1:0] taps
);

   // Each stage gets its own kept wire so the tools cannot collapse the chain
   for (genvar i = 0; i < CHAIN_LEN; i++) begin : gCell
      logic cellIn;
      (* keep = "true" *) logic cellOut;

      if (i == 0) begin : gHead
         assign cellIn = launch;
      end else begin : gLink
         assign cellIn = gCell[i-1].cellOut;
      end

      singlepath_3_spy_p35 uCell (
         .pathIn (cellIn),
         .sideA  (CELL_SIDE_A),
         .sideB  (CELL_SIDE_B),
         .sideC  (CELL_SIDE_C),
         .sideD  (CELL_SIDE_D),
         .pathOut(cellOut)
      );
   end

   // An odd number of inversions flips the tap, so a 1 always means "edge arrived"
   for (genvar k = 0; k < NUM_TAPS; k++) begin : gTap
      localparam int   DEPTH    = (k + 1) * TAP_STRIDE;
      localparam logic INVERTED = 1'(DEPTH % 2);
      assign taps[k] = gCell[DEPTH-1].cellOut ^ INVERTED;
   end

endmodule

// File: rtl/spy_chain_sensor.sv
// Delay-line timing sensor: launches an edge, captures tap depth one clock later,
// and reports mean/min/max/saturation over 2^AVG_LOG2 samples.
module spy_chain_sensor
   import spy_pkg::*;
#(
   parameter  int CHAIN_LEN  = DEFAULT_CHAIN_LEN,
   parameter  int TAP_STRIDE = DEFAULT_TAP_STRIDE,
   parameter  int AVG_LOG2   = 3,
   parameter  int SETTLE_CYC = 4,
   localparam int NUM_TAPS   = CHAIN_LEN / TAP_STRIDE,
   localparam int TAP_W      = spyClog2(NUM_TAPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             continuous,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [TAP_W-1:0] result_mean,
   output logic [TAP_W-1:0] result_min,
   output logic [TAP_W-1:0] result_max,
   output logic             saturated
);

   localparam int NUM_SAMPLES = 1 << AVG_LOG2;
   localparam int SUM_W       = TAP_W + AVG_LOG2;
   localparam int IDX_W       = AVG_LOG2 + 1;
   localparam int SETTLE_W    = spyClog2(SETTLE_CYC + 1);

   SpyState             state;
   SpyState             nextState;
   logic                clearAcc;
   logic                launch;
   logic [NUM_TAPS-1:0] correctedTaps;
   (* ASYNC_REG = "TRUE", keep = "true" *) logic [NUM_TAPS-1:0] cap1;
   logic [NUM_TAPS-1:0] cap2;
   logic [TAP_W-1:0]    depth;
   logic [SUM_W-1:0]    sumAcc;
   logic [IDX_W-1:0]    sampleIdx;
   logic [TAP_W-1:0]    minAcc;
   logic [TAP_W-1:0]    maxAcc;
   logic                satAcc;
   logic [SETTLE_W-1:0] settleCnt;
   logic                lastSettle;
   logic                enterDone;

   spy_tap_chain #(
      .CHAIN_LEN (CHAIN_LEN),
      .TAP_STRIDE(TAP_STRIDE)
   ) uTapChain (
      .launch(launch),
      .taps  (correctedTaps)
   );

   // Popcount rather than thermometer decode so capture bubbles do not skew depth
   assign depth        = TAP_W'($countones(cap2));
   assign lastSettle   = (settleCnt == SETTLE_W'(SETTLE_CYC - 1));
   assign enterDone    = (state == SETTLE) && (nextState == DONE);
   assign busy         = (state != IDLE);
   assign result_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      clearAcc  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = LAUNCH;
               clearAcc  = 1'b1;
            end
         end
         LAUNCH: nextState = SAMPLE;
         SAMPLE: nextState = SYNC;
         SYNC:   nextState = EVAL;
         EVAL:   nextState = SETTLE;
         SETTLE: begin
            if (lastSettle)
               nextState = (sampleIdx == IDX_W'(NUM_SAMPLES)) ? DONE : LAUNCH;
         end
         DONE: begin
            if (result_ready) begin
               nextState = continuous ? LAUNCH : IDLE;
               clearAcc  = continuous;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          settleCnt <= '0;
      else if (state == SETTLE && !lastSettle) settleCnt <= settleCnt + SETTLE_W'(1);
      else                                 settleCnt <= '0;
   end

   // Launch, two-stage capture and per-sample accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         launch    <= 1'b0;
         cap1      <= '0;
         cap2      <= '0;
         sumAcc    <= '0;
         sampleIdx <= '0;
         minAcc    <= '1;
         maxAcc    <= '0;
         satAcc    <= 1'b0;
      end else begin
         if (clearAcc) begin
            sumAcc    <= '0;
            sampleIdx <= '0;
            minAcc    <= '1;
            maxAcc    <= '0;
            satAcc    <= 1'b0;
         end
         case (state)
            LAUNCH: launch <= 1'b1;
            SAMPLE: cap1   <= correctedTaps;
            SYNC:   cap2   <= cap1;
            EVAL: begin
               sumAcc    <= sumAcc + SUM_W'(depth);
               sampleIdx <= sampleIdx + IDX_W'(1);
               if (depth < minAcc) minAcc <= depth;
               if (depth > maxAcc) maxAcc <= depth;
               satAcc    <= satAcc | (depth == TAP_W'(NUM_TAPS));
               launch    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Results only move on entry to DONE so the consumer sees a frozen set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_mean <= '0;
         result_min  <= '0;
         result_max  <= '0;
         saturated   <= 1'b0;
      end else if (enterDone) begin
         result_mean <= TAP_W'(sumAcc >> AVG_LOG2);
         result_min  <= minAcc;
         result_max  <= maxAcc;
         saturated   <= satAcc;
      end
   end

endmodule
